// File: rtl/counter_sequencer.sv
// counter_sequencer: expands host commands into per-cycle strobes for the counter/shift datapath.
// Build option SEQ_ROTATE_EN: shift ops rotate the datapath value instead of serialising CmdData.
module counter_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              Clock,
  input  logic              DoReset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [2:0]        CmdOp,
  input  logic [DATA_W-1:0] CmdData,
  input  logic [CNT_W-1:0]  CmdCount,
  output logic              Done,
  output logic              Error,
  input  logic [DATA_W-1:0] DpCounterOut,
  output logic              DpReset,
  output logic              DpLoad,
  output logic              DpIncrement,
  output logic              DpDecrement,
  output logic              DpShiftL2R,
  output logic              DpShiftR2L,
  output logic [DATA_W-1:0] DpInData,
  output logic              DpInMSB,
  output logic              DpInLSB
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_CLEAR, OP_LOAD, OP_INC, OP_DEC, OP_SHL2R, OP_SHR2L, OP_RSVD
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    index_q, index_d;
  logic                shl_bit, shr_bit;

  // Next-state: latch the command on acceptance, step the repeat index in EXEC.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    index_d = index_q;
    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          op_d    = op_t'(CmdOp);
          data_d  = CmdData;
          count_d = CmdCount;
          index_d = '0;
          case (op_t'(CmdOp))
            OP_CLEAR, OP_LOAD:                   state_d = S_EXEC;
            OP_INC, OP_DEC, OP_SHL2R, OP_SHR2L:  state_d = (CmdCount != '0) ? S_EXEC : S_DONE;
            default:                             state_d = S_DONE;
          endcase
        end
      end
      S_EXEC: begin
        if (op_q == OP_CLEAR || op_q == OP_LOAD || index_q == count_q - CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (DoReset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      count_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      index_q <= index_d;
    end
  end

`ifdef SEQ_ROTATE_EN
  assign shl_bit = DpCounterOut[0];
  assign shr_bit = DpCounterOut[DATA_W-1];
`else
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] rev_idx;
  logic             unused_fb;

  // Serial source bit wraps modulo DATA_W for repeat counts beyond one word.
  assign bit_idx   = IDX_W'(32'(index_q) % DATA_W);
  assign rev_idx   = IDX_W'(DATA_W - 1) - bit_idx;
  assign shl_bit   = data_q[bit_idx];
  assign shr_bit   = data_q[rev_idx];
  assign unused_fb = ^DpCounterOut;
`endif

  // Output decode from registered state; strobes only in EXEC, one per cycle.
  always_comb begin
    CmdReady    = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    DpReset     = 1'b0;
    DpLoad      = 1'b0;
    DpIncrement = 1'b0;
    DpDecrement = 1'b0;
    DpShiftL2R  = 1'b0;
    DpShiftR2L  = 1'b0;
    DpInMSB     = 1'b0;
    DpInLSB     = 1'b0;
    DpInData    = data_q;
    case (state_q)
      S_IDLE: CmdReady = 1'b1;
      S_DONE: begin
        Done  = 1'b1;
        Error = (op_q == OP_RSVD);
      end
      S_EXEC: begin
        case (op_q)
          OP_CLEAR: DpReset     = 1'b1;
          OP_LOAD:  DpLoad      = 1'b1;
          OP_INC:   DpIncrement = 1'b1;
          OP_DEC:   DpDecrement = 1'b1;
          OP_SHL2R: begin
            DpShiftL2R = 1'b1;
            DpInMSB    = shl_bit;
          end
          OP_SHR2L: begin
            DpShiftR2L = 1'b1;
            DpInLSB    = shr_bit;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed commands checked every cycle against a command-schedule model,
// with a behavioural counter datapath closing the feedback loop and literal result checks.
`timescale 1ns/1ps
module tb_counter_sequencer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              DoReset, CmdValid, CmdReady, Done, Error;
  logic [2:0]        CmdOp;
  logic [DATA_W-1:0] CmdData, DpCounterOut, DpInData;
  logic [CNT_W-1:0]  CmdCount;
  logic DpReset, DpLoad, DpIncrement, DpDecrement, DpShiftL2R, DpShiftR2L, DpInMSB, DpInLSB;

  always #5 clk = ~clk;

  counter_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clock(clk), .DoReset(DoReset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .CmdCount(CmdCount), .Done(Done), .Error(Error),
    .DpCounterOut(DpCounterOut), .DpReset(DpReset), .DpLoad(DpLoad),
    .DpIncrement(DpIncrement), .DpDecrement(DpDecrement), .DpShiftL2R(DpShiftL2R),
    .DpShiftR2L(DpShiftR2L), .DpInData(DpInData), .DpInMSB(DpInMSB), .DpInLSB(DpInLSB)
  );

  // Counter/shift datapath driven by the strobes; not touched by DoReset.
  logic [15:0] dp_q;
  logic        dp_preset;
  assign DpCounterOut = dp_q;
  always @(posedge clk) begin
    if (dp_preset)        dp_q <= 16'h1357;
    else if (DpReset)     dp_q <= 16'h0000;
    else if (DpLoad)      dp_q <= DpInData;
    else if (DpIncrement) dp_q <= dp_q + 16'd1;
    else if (DpDecrement) dp_q <= dp_q - 16'd1;
    else if (DpShiftL2R)  dp_q <= {DpInMSB, dp_q[15:1]};
    else if (DpShiftR2L)  dp_q <= {dp_q[14:0], DpInLSB};
  end

  // Written only by the driver, read by the compare process.
  bit          lit_en = 1'b0;
  logic [15:0] lit_val = 16'h0;
  bit          hold_en = 1'b0;
  logic [15:0] hold_val = 16'h0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  // Model: command accepted in cycle a -> strobes in a+1..a+len, Done in a+len+1.
  int          cyc = 0;
  bit          started = 1'b0;
  bit          active = 1'b0;
  int          acc_c = 0;
  int          m_op = 0;
  int          m_count = 0;
  logic [15:0] m_data = 16'h0;

  always @(negedge clk) begin : compare
    int t, len, i;
    logic [8:0] exp_v, act_v;
    logic exp_bit;
    exp_v = 9'h100;
    if (started) begin
      t   = cyc - acc_c;
      len = (m_op == 1 || m_op == 2) ? 1 : (m_op >= 3 && m_op <= 6) ? m_count : 0;
      if (active && t <= len)
        exp_v = {3'b000, 6'(1 << (6 - m_op))};
      else if (active && t == len + 1)
        exp_v = {1'b0, 1'b1, (m_op == 7), 6'b0};
      act_v = {CmdReady, Done, Error, DpReset, DpLoad, DpIncrement, DpDecrement,
               DpShiftL2R, DpShiftR2L};
      check("ready_done_err_strobes", 16'(act_v), 16'(exp_v));
      if (active && t <= len) begin
        i = t - 1;
        if (m_op == 2) check("load_data", DpInData, m_data);
`ifdef SEQ_ROTATE_EN
        if (m_op == 5) begin exp_bit = DpCounterOut[0];  check("shl2r_msb", 16'(DpInMSB), 16'(exp_bit)); end
        if (m_op == 6) begin exp_bit = DpCounterOut[15]; check("shr2l_lsb", 16'(DpInLSB), 16'(exp_bit)); end
`else
        if (m_op == 5) begin exp_bit = m_data[i % 16];      check("shl2r_msb", 16'(DpInMSB), 16'(exp_bit)); end
        if (m_op == 6) begin exp_bit = m_data[15 - i % 16]; check("shr2l_lsb", 16'(DpInLSB), 16'(exp_bit)); end
`endif
      end
      if (exp_v[7] && lit_en) check("result_at_done", DpCounterOut, lit_val);
      if (hold_en) check("counter_hold", DpCounterOut, hold_val);
    end
    if (DoReset) begin
      started = 1'b1;
      active  = 1'b0;
    end else if (started && exp_v[8] && CmdValid) begin
      active  = 1'b1;
      acc_c   = cyc;
      m_op    = int'(CmdOp);
      m_data  = CmdData;
      m_count = int'(CmdCount);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the command until accepted, then scramble the command inputs.
  task automatic issue(input logic [2:0] op, input logic [15:0] data, input logic [4:0] cnt,
                       input bit le, input logic [15:0] lv);
    bit r;
    CmdOp = op; CmdData = data; CmdCount = cnt; CmdValid = 1'b1;
    r = 1'b0;
    for (int n = 0; n < 100 && !r; n++) begin
      @(negedge clk);
      r = CmdReady;
      tick();
    end
    if (!r) begin
      $display("FAIL accept_timeout op %0d: got ready 0, want 1", op);
      $fatal(1, "accept timeout");
    end
    CmdValid = 1'b0;
    CmdOp    = 3'($urandom);
    CmdData  = 16'($urandom);
    CmdCount = 5'($urandom);
    lit_en   = le;
    lit_val  = lv;
  endtask

  task automatic wait_idle();
    bit r;
    r = 1'b0;
    for (int n = 0; n < 200 && !r; n++) begin
      @(negedge clk);
      r = CmdReady;
    end
    if (!r) begin
      $display("FAIL idle_timeout: got ready 0, want 1");
      $fatal(1, "idle timeout");
    end
    tick();
  endtask

  task automatic run(input logic [2:0] op, input logic [15:0] data, input logic [4:0] cnt,
                     input bit le, input logic [15:0] lv);
    issue(op, data, cnt, le, lv);
    wait_idle();
  endtask

  initial begin
    DoReset = 1'b1; CmdValid = 1'b0; CmdOp = 3'd0; CmdData = 16'h0; CmdCount = 5'd0;
    dp_preset = 1'b1;
    tick();
    dp_preset = 1'b0;
    hold_val = 16'h1357; hold_en = 1'b1;
    tick();
    DoReset = 1'b0;
    repeat (3) tick();
    hold_en = 1'b0;

    run(3'd1, 16'h0000, 5'd0, 1'b1, 16'h0000);
    run(3'd2, 16'hBEEF, 5'd0, 1'b1, 16'hBEEF);
    run(3'd2, 16'hFFFE, 5'd0, 1'b1, 16'hFFFE);
    run(3'd3, 16'h0000, 5'd3, 1'b1, 16'h0001);
    run(3'd4, 16'h0000, 5'd0, 1'b1, 16'h0001);
    run(3'd2, 16'h0001, 5'd0, 1'b1, 16'h0001);
    run(3'd4, 16'h0000, 5'd3, 1'b1, 16'hFFFE);

    run(3'd1, 16'h0000, 5'd0, 1'b1, 16'h0000);
`ifdef SEQ_ROTATE_EN
    run(3'd5, 16'hA5C3, 5'd16, 1'b1, 16'h0000);
    run(3'd6, 16'h1234, 5'd16, 1'b1, 16'h0000);
`else
    run(3'd5, 16'hA5C3, 5'd16, 1'b1, 16'hA5C3);
    run(3'd6, 16'h1234, 5'd16, 1'b1, 16'h1234);
`endif
    run(3'd5, 16'h5A5A, 5'd20, 1'b0, 16'h0000);
    run(3'd6, 16'h0F31, 5'd31, 1'b0, 16'h0000);

    issue(3'd3, 16'h0000, 5'd5, 1'b0, 16'h0000);
    run(3'd2, 16'h0F0F, 5'd0, 1'b1, 16'h0F0F);
    run(3'd7, 16'hFFFF, 5'd9, 1'b1, 16'h0F0F);
    run(3'd0, 16'h1111, 5'd4, 1'b1, 16'h0F0F);

    run(3'd2, 16'h0010, 5'd0, 1'b1, 16'h0010);
    issue(3'd3, 16'h0000, 5'd10, 1'b0, 16'h0000);
    tick();
    tick();
    DoReset = 1'b1;
    tick();
    DoReset = 1'b0;
    hold_val = 16'h0013; hold_en = 1'b1;
    repeat (4) tick();
    hold_en = 1'b0;

    run(3'd2, 16'h8001, 5'd0, 1'b1, 16'h8001);
    run(3'd5, 16'h0001, 5'd1, 1'b1, 16'hC000);
    run(3'd6, 16'h8000, 5'd1, 1'b1, 16'h8001);
    run(3'd3, 16'h0000, 5'd31, 1'b1, 16'h8020);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
